// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and field positions for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

    localparam int INSTR_W     = 16;
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int FIELDA_MSB  = 11;
    localparam int FIELDA_LSB  = 8;
    localparam int OPERAND_MSB = 7;
    localparam int OPERAND_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the program-memory beat bus, the instruction valid/take handshake
// and the redirect port. The fetch unit is the master; memory plus consumer
// sit on the slave side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic              instr_take;
    logic [3:0]        opcode;
    logic [3:0]        field_a;
    logic [7:0]        operand;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    modport master (
        output mem_addr, mem_req,
        input  mem_ack, mem_rdata,
        output instr_valid, opcode, field_a, operand, instr_pc,
        input  instr_take, redirect, redirect_addr
    );

    modport slave (
        input  mem_addr, mem_req,
        output mem_ack, mem_rdata,
        input  instr_valid, opcode, field_a, operand, instr_pc,
        output instr_take, redirect, redirect_addr
    );
endinterface

// File: rtl/instr_fetch_unit_instr_slot.sv
// One instruction slot: 16-bit instruction word, its fetch address and a
// valid bit. Load takes priority over clear so a slot can be refilled in the
// same cycle its previous contents are consumed.
module ifu_instr_slot
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_ir,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);

    // Slot contents; clearing only drops valid so the fields stay quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir    <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            ir    <= load_ir;
            pc    <= load_pc;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and reads each 16-bit instruction as two byte
// beats (high byte at PC, low byte at PC+1), presenting decoded fields with
// a valid/take handshake. Redirect flushes and restarts fetching.
// Optional macro IFU_PREFETCH_EN adds a one-entry prefetch buffer so the
// unit keeps fetching while an instruction is held.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_next;
    logic [7:0]         hi_byte;
    logic               hi_capture;
    logic               beat;
    logic               take_ok;
    logic [INSTR_W-1:0] new_instr;

    logic               ir_load, ir_clear, ir_valid;
    logic [INSTR_W-1:0] ir_load_data, ir_q;
    logic [ADDR_W-1:0]  ir_load_pc, ir_pc;

`ifdef IFU_PREFETCH_EN
    logic               buf_load, buf_clear, buf_valid;
    logic [INSTR_W-1:0] buf_q;
    logic [ADDR_W-1:0]  buf_pc;
`endif

    assign beat      = bus.mem_req && bus.mem_ack;
    assign take_ok   = bus.instr_take && ir_valid;
    assign new_instr = {hi_byte, bus.mem_rdata};

    assign bus.mem_req  = !reset && (state != HOLD);
    assign bus.mem_addr = (state == FETCH_LO) ? fetch_pc + 1'b1 : fetch_pc;

    // State register, fetch PC and the captured high byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_HI;
            fetch_pc <= RESET_PC;
            hi_byte  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (hi_capture) begin
                hi_byte <= bus.mem_rdata;
            end
        end
    end

    // Next-state and slot control; redirect overrides everything at the end.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        hi_capture    = 1'b0;
        ir_load       = 1'b0;
        ir_clear      = 1'b0;
        ir_load_data  = new_instr;
        ir_load_pc    = fetch_pc;
`ifdef IFU_PREFETCH_EN
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
`endif
        case (state)
            FETCH_HI: begin
`ifdef IFU_PREFETCH_EN
                ir_clear = take_ok;
`endif
                if (beat) begin
                    hi_capture = 1'b1;
                    state_next = FETCH_LO;
                end
            end
            FETCH_LO: begin
`ifdef IFU_PREFETCH_EN
                ir_clear = take_ok;
`endif
                if (beat) begin
                    fetch_pc_next = fetch_pc + ADDR_W'(2);
`ifdef IFU_PREFETCH_EN
                    if (!ir_valid || take_ok) begin
                        ir_load    = 1'b1;
                        state_next = FETCH_HI;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = HOLD;
                    end
`else
                    ir_load    = 1'b1;
                    state_next = HOLD;
`endif
                end
            end
            HOLD: begin
                if (take_ok) begin
`ifdef IFU_PREFETCH_EN
                    ir_load      = 1'b1;
                    ir_load_data = buf_q;
                    ir_load_pc   = buf_pc;
                    buf_clear    = 1'b1;
`else
                    ir_clear     = 1'b1;
`endif
                    state_next = FETCH_HI;
                end
            end
            default: state_next = FETCH_HI;
        endcase

        if (bus.redirect) begin
            state_next    = FETCH_HI;
            fetch_pc_next = bus.redirect_addr;
            hi_capture    = 1'b0;
            ir_load       = 1'b0;
            ir_clear      = 1'b1;
`ifdef IFU_PREFETCH_EN
            buf_load      = 1'b0;
            buf_clear     = 1'b1;
`endif
        end
    end

    ifu_instr_slot #(.ADDR_W(ADDR_W)) u_ir_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (ir_load),
        .clear   (ir_clear),
        .load_ir (ir_load_data),
        .load_pc (ir_load_pc),
        .ir      (ir_q),
        .pc      (ir_pc),
        .valid   (ir_valid)
    );

`ifdef IFU_PREFETCH_EN
    ifu_instr_slot #(.ADDR_W(ADDR_W)) u_buf_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .clear   (buf_clear),
        .load_ir (new_instr),
        .load_pc (fetch_pc),
        .ir      (buf_q),
        .pc      (buf_pc),
        .valid   (buf_valid)
    );
`endif

    assign bus.instr_valid = ir_valid;
    assign bus.opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.field_a     = ir_q[FIELDA_MSB:FIELDA_LSB];
    assign bus.operand     = ir_q[OPERAND_MSB:OPERAND_LSB];
    assign bus.instr_pc    = ir_pc;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the control unit. It owns the program counter and reads each 16-bit instruction as two byte beats from byte-wide program memory: high byte at PC, low byte at PC+1. It presents the decoded fields (opcode, register field, operand byte) with a valid/take handshake. Jumps and branches enter through a redirect port.

Parameters:
ADDR_W, 8, program address width; PC wraps modulo 2^ADDR_W
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mem_addr  out  ADDR_W  program memory byte address
mem_req  out  1  read request; held with mem_addr stable until accepted
mem_ack  in  1  beat complete; mem_rdata valid in the same cycle
mem_rdata  in  8  read data
instr_valid  out  1  instruction held, fields valid
instr_take  in  1  consumer accepts current instruction
opcode  out  4  ir[15:12]
field_a  out  4  ir[11:8]
operand  out  8  ir[7:0]
instr_pc  out  ADDR_W  address of the high byte of the held instruction
redirect  in  1  load new fetch address, flush
redirect_addr  in  ADDR_W  new fetch address (odd values legal)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC, state = FETCH_HI.
  - mem_req = 0, mem_addr = RESET_PC.
  - instr_valid = 0; opcode, field_a, operand and instr_pc = 0.
- mem_req rises in the first cycle after reset deasserts.
- Beat handshake: a beat completes in any cycle where mem_req && mem_ack; mem_rdata is sampled in that cycle. Zero-wait operation (ack in the same cycle as req) is legal.
- FSM states: FETCH_HI, FETCH_LO, HOLD.
  - FETCH_HI: mem_addr = fetch_pc, mem_req = 1. On beat, capture hi byte, go to FETCH_LO.
  - FETCH_LO: mem_addr = fetch_pc+1 (mod 2^ADDR_W), mem_req = 1. On beat:
    - load IR = {hi, rdata}; instr_pc = fetch_pc; fetch_pc += 2 (mod);
    - go to HOLD; instr_valid = 1 from the next cycle.
  - HOLD: mem_req = 0, instr_valid = 1, fields stable. When instr_take = 1:
    - the next cycle has instr_valid = 0;
    - the state is FETCH_HI with mem_req = 1 in that same cycle.
- Latency: with zero-wait memory, instr_valid rises 2 cycles after the first req. Minimum cost is 3 cycles per instruction.
- instr_take while instr_valid = 0 is ignored.
- Redirect has highest priority after reset. On a cycle with redirect = 1:
  - any outstanding or same-cycle beat is discarded;
  - a same-cycle instr_take is void (the held instruction is dropped);
  - in the next cycle: fetch_pc = redirect_addr, state = FETCH_HI, instr_valid = 0, mem_req = 1, mem_addr = redirect_addr.
  - Program memory accepts a change of address on an un-acked request.
- Back-to-back redirects: the last one wins.
- Reset mid-beat: the beat is abandoned and all state returns to reset values.

Optional Feature:
IFU_PREFETCH_EN
- Defined: adds a one-entry prefetch buffer.
  - In HOLD, the unit keeps fetching the next instruction (fetch_pc, fetch_pc+1) into the buffer.
  - mem_req drops only when the buffer is full.
  - On instr_take with the buffer full, the buffer moves to IR in the next cycle and instr_valid stays 1. Fetching of the following instruction resumes immediately.
  - Redirect flushes IR and the buffer.
  - Sustained rate: one instruction per 2 beats.
- Undefined: no buffer; behaviour exactly as in Behaviour.

Decomposition:
- Package ifu_pkg:
  - state enum FETCH_HI/FETCH_LO/HOLD;
  - INSTR_W = 16;
  - field positions OPCODE_MSB/LSB = 15/12, FIELDA_MSB/LSB = 11/8, OPERAND_MSB/LSB = 7/0.
- Sub-module ifu_instr_slot: 16-bit instruction register plus valid bit plus pc, with load/clear controls.
  - Instantiated once normally, twice under IFU_PREFETCH_EN.

Test Plan:
1. Reset, memory [0x00] = 0x1A, [0x01] = 0x3C, zero-wait -> req at addr 0x00, then 0x01; next cycle instr_valid = 1, opcode = 0x1, field_a = 0xA, operand = 0x3C, instr_pc = 0x00.
2. mem_ack delayed 3 cycles on each beat -> mem_addr and mem_req stay stable while waiting; instr_valid rises only after both beats; fields as in case 1.
3. Hold without take for 5 cycles -> fields stable, mem_req = 0. Pulse instr_take -> next cycle instr_valid = 0, mem_req = 1, mem_addr = 0x02.
4. Redirect to 0xFF -> beats at 0xFF, then 0x00; instr_pc = 0xFF; the next fetch after take is at 0x01.
5. Redirect to 0x40 in the same cycle as the FETCH_LO ack and as instr_take -> the acked byte is discarded and instr_valid never rises with the old data; the next cycle has mem_addr = 0x40, mem_req = 1.
6. With IFU_PREFETCH_EN, hold without take -> two more beats (0x02, 0x03), then mem_req = 0. Take -> instr_valid stays 1, instr_pc = 0x02 in the next cycle, and fetching resumes at 0x04.
